// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, tap indices and the saturation helper
// for the 3x3 convolution stage.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 2*DATA_W + 5;
    localparam int N_TAPS = 9;

    localparam logic [3:0] TAP_00   = 4'd0;
    localparam logic [3:0] TAP_01   = 4'd1;
    localparam logic [3:0] TAP_02   = 4'd2;
    localparam logic [3:0] TAP_10   = 4'd3;
    localparam logic [3:0] TAP_11   = 4'd4;
    localparam logic [3:0] TAP_12   = 4'd5;
    localparam logic [3:0] TAP_20   = 4'd6;
    localparam logic [3:0] TAP_21   = 4'd7;
    localparam logic [3:0] TAP_22   = 4'd8;
    localparam logic [3:0] BIAS_IDX = 4'd9;

    localparam logic signed [ACC_W-1:0] PIX_MAX =
        ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] PIX_MIN = ~PIX_MAX;

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] pix;
    } sat_t;

    function automatic sat_t saturate(
        input logic signed [ACC_W-1:0] v
    );
        sat_t r;
        if (v > PIX_MAX) begin
            r.sat = 1'b1;
            r.pix = PIX_MAX[DATA_W-1:0];
        end else if (v < PIX_MIN) begin
            r.sat = 1'b1;
            r.pix = PIX_MIN[DATA_W-1:0];
        end else begin
            r.sat = 1'b0;
            r.pix = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// conv_sat_shift: arithmetic shift, saturation and optional ReLU
// (enabled by the CONV_RELU_EN macro) for requantizing an accumulator.
module conv_sat_shift
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic [ACC_W-1:0]  sum_in,
    output logic [DATA_W-1:0] pix,
    output logic              sat
);

    logic signed [ACC_W-1:0] shifted;
    sat_t                    r;

    always_comb begin
        shifted = $signed(sum_in) >>> SHIFT;
        r       = saturate(shifted);
        sat     = r.sat;
        pix     = r.pix;
`ifdef CONV_RELU_EN
        // ReLU clamp is not a saturation event; sat is left untouched
        if (r.pix[DATA_W-1]) pix = '0;
`endif
    end

endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3-stage pipelined 3x3 MAC with bias, requantization and
// row-wrap masking. Optional ReLU output via CONV_RELU_EN.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] p00,
    input  logic [DATA_W-1:0] p01,
    input  logic [DATA_W-1:0] p02,
    input  logic [DATA_W-1:0] p10,
    input  logic [DATA_W-1:0] p11,
    input  logic [DATA_W-1:0] p12,
    input  logic [DATA_W-1:0] p20,
    input  logic [DATA_W-1:0] p21,
    input  logic [DATA_W-1:0] p22,
    input  logic              w_load,
    input  logic [3:0]        w_idx,
    input  logic [BIAS_W-1:0] w_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] pix_out,
    output logic              sat_flag
);

    localparam int COL_W = $clog2(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);

    logic signed [DATA_W-1:0]   win  [N_TAPS];
    logic signed [DATA_W-1:0]   wgt  [N_TAPS];
    logic signed [BIAS_W-1:0]   bias;
    logic signed [2*DATA_W-1:0] prod [N_TAPS];
    logic signed [ACC_W-1:0]    row  [3];
    logic signed [BIAS_W-1:0]   bias1, bias2;
    logic signed [ACC_W-1:0]    total;
    logic                       v1, v2;
    logic [COL_W-1:0]           col, col_eff;
    logic                       accept;
    logic [DATA_W-1:0]          s3_pix;
    logic                       s3_sat;

    always_comb begin
        win[TAP_00] = p00;
        win[TAP_01] = p01;
        win[TAP_02] = p02;
        win[TAP_10] = p10;
        win[TAP_11] = p11;
        win[TAP_12] = p12;
        win[TAP_20] = p20;
        win[TAP_21] = p21;
        win[TAP_22] = p22;
    end

    // sof aliases this beat to column 0 so the frame restarts cleanly
    always_comb begin
        col_eff = sof ? '0 : col;
        accept  = in_valid && (col_eff >= COL_MIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
        end else if (in_valid) begin
            col <= (col_eff == COL_LAST) ? '0 : col_eff + 1'b1;
        end else if (sof) begin
            col <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) wgt[i] <= '0;
            bias <= '0;
        end else if (w_load) begin
            for (int i = 0; i < N_TAPS; i++)
                if (w_idx == 4'(i)) wgt[i] <= w_data[DATA_W-1:0];
            if (w_idx == BIAS_IDX) bias <= w_data;
        end
    end

    // S1: products; bias rides along so each window sees one kernel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            bias1 <= '0;
            for (int i = 0; i < N_TAPS; i++) prod[i] <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                bias1 <= bias;
                for (int i = 0; i < N_TAPS; i++)
                    prod[i] <= win[i] * wgt[i];
            end
        end
    end

    // S2: one partial sum per kernel row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            bias2 <= '0;
            for (int r = 0; r < 3; r++) row[r] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                bias2 <= bias1;
                for (int r = 0; r < 3; r++)
                    row[r] <= ACC_W'(prod[3*r])
                            + ACC_W'(prod[3*r+1])
                            + ACC_W'(prod[3*r+2]);
            end
        end
    end

    assign total = row[0] + row[1] + row[2] + ACC_W'(bias2);

    conv_sat_shift #(
        .SHIFT (SHIFT)
    ) u_sat (
        .sum_in (total),
        .pix    (s3_pix),
        .sat    (s3_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pix_out   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                pix_out  <= s3_pix;
                sat_flag <= s3_sat;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: scoreboard bench driving two instances (SHIFT=0 and
// SHIFT=1) with identical stimulus.
module tb_conv3x3_mac;

    localparam int IMG_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof, in_valid, w_load;
    logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [3:0]  w_idx;
    logic [15:0] w_data;
    logic        ov0, ov1, sat0, sat1;
    logic [7:0]  pix0, pix1;

    typedef struct {
        int p0;
        int s0;
        int p1;
        int s1;
        int t;
    } exp_t;

    exp_t sb[$];
    int   px [9];
    int   mw [9];
    int   mb;
    int   mcol;
    int   cyc;
    int   n_chk;
    int   n_err;
    int   n_out;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv3x3_mac #(.IMG_W(IMG_W), .BIAS_W(16), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .p00(p00), .p01(p01), .p02(p02),
        .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
        .out_valid(ov0), .pix_out(pix0), .sat_flag(sat0)
    );

    conv3x3_mac #(.IMG_W(IMG_W), .BIAS_W(16), .SHIFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .p00(p00), .p01(p01), .p02(p02),
        .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
        .out_valid(ov1), .pix_out(pix1), .sat_flag(sat1)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: sum, floor shift, clip, optional ReLU; returns {sat,pix}
    function automatic int ref_pix(input int sh, output int sat);
        int acc, s;
        acc = mb;
        for (int i = 0; i < 9; i++) acc += mw[i] * px[i];
        s   = acc >>> sh;
        sat = 0;
        if (s > 127) begin
            s = 127; sat = 1;
        end else if (s < -128) begin
            s = -128; sat = 1;
        end
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic step(input logic v, input logic s, input logic wl,
                        input logic [3:0] wi, input logic [15:0] wd);
        int   c;
        exp_t e;
        in_valid = v; sof = s; w_load = wl; w_idx = wi; w_data = wd;
        p00 = 8'(px[0]); p01 = 8'(px[1]); p02 = 8'(px[2]);
        p10 = 8'(px[3]); p11 = 8'(px[4]); p12 = 8'(px[5]);
        p20 = 8'(px[6]); p21 = 8'(px[7]); p22 = 8'(px[8]);
        c = s ? 0 : mcol;
        if (v && c >= 2) begin
            e.p0 = ref_pix(0, e.s0);
            e.p1 = ref_pix(1, e.s1);
            e.t  = cyc;
            sb.push_back(e);
        end
        if (v) mcol = (c == IMG_W - 1) ? 0 : c + 1;
        else if (s) mcol = 0;
        if (wl) begin
            if (wi < 9) mw[wi] = int'($signed(wd[7:0]));
            else if (wi == 9) mb = int'($signed(wd));
        end
        @(posedge clk); #1;
        in_valid = 0; sof = 0; w_load = 0;
    endtask

    task automatic wr(input int idx, input int val);
        step(1'b0, 1'b0, 1'b1, 4'(idx), 16'(val));
    endtask

    task automatic set_px(input int val);
        for (int i = 0; i < 9; i++) px[i] = val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    // sof-aligned row of IMG_W beats: cols 0,1 dropped, 2,3 accepted
    task automatic row4();
        step(1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
        for (int i = 1; i < IMG_W; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ov0 || ov1)) begin
            n_out++;
            check("ov_pair", ov1, ov0);
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pix_s0", $signed(pix0), e.p0);
                check("sat_s0", sat0, e.s0);
                check("pix_s1", $signed(pix1), e.p1);
                check("sat_s1", sat1, e.s1);
                check("latency", cyc - e.t, 3);
            end
        end
    end

    initial begin
        int n0;
        n_chk = 0; n_err = 0; n_out = 0; cyc = 0;
        rst_n = 0; sof = 0; in_valid = 0; w_load = 0;
        w_idx = 0; w_data = 0;
        mcol = 0; mb = 0;
        for (int i = 0; i < 9; i++) mw[i] = 0;
        set_px(0);
        p00 = 0; p01 = 0; p02 = 0; p10 = 0; p11 = 0;
        p12 = 0; p20 = 0; p21 = 0; p22 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", ov0, 0);
        check("rst_pix", pix0, 0);
        check("rst_sat", sat0, 0);
        rst_n = 1;
        idle(2);

        // identity kernel, constant window 10
        for (int i = 0; i < 9; i++) wr(i, 1);
        wr(9, 0);
        set_px(10);
        row4();
        idle(4);

        // saturation both directions
        for (int i = 0; i < 9; i++) wr(i, 127);
        set_px(127);
        row4();
        set_px(-127);
        row4();
        idle(4);

        // row-wrap masking: sof alone, then 8 beats with distinct pixels
        for (int i = 0; i < 9; i++) wr(i, 1);
        n0 = n_out;
        step(1'b0, 1'b1, 1'b0, 4'd0, 16'd0);
        for (int b = 1; b <= 8; b++) begin
            set_px(b);
            step(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        end
        idle(5);
        check("wrap_count", n_out - n0, 4);

        // floor rounding and bias
        for (int i = 0; i < 9; i++) wr(i, 0);
        wr(4, 1);
        wr(9, 0);
        set_px(0);
        px[4] = -3;
        row4();
        wr(9, 5);
        row4();
        idle(4);

        // weight write on the same edge as an accepted window
        wr(9, 0);
        px[4] = 10;
        step(1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        step(1'b1, 1'b0, 1'b1, 4'd4, 16'd2);
        step(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        idle(4);

        // async reset with two windows in flight
        wr(9, 3);
        row4();
        rst_n = 0;
        sb.delete();
        mcol = 0; mb = 0;
        for (int i = 0; i < 9; i++) mw[i] = 0;
        #1;
        check("arst_ov", ov0, 0);
        check("arst_pix", pix0, 0);
        check("arst_sat", sat0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ov", ov0, 0);
        @(posedge clk); #1;
        idle(3);
        set_px(1);
        row4();
        idle(5);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
